// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: frame size, FSM state encoding and
// counter sizing helper used by both the receive and transmit paths.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned baudsel);
        return $clog2(2 * baudsel) + 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser plus edge-detect flop, mid-bit sampling
// FSM and a valid/ready holding register for the received byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUDSEL = 625
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data
);

    localparam int unsigned CW = cnt_width(BAUDSEL);
    localparam logic [CW-1:0] HALF = CW'(BAUDSEL - 1);
    localparam logic [CW-1:0] FULL = CW'(2 * BAUDSEL - 1);
    localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

    logic                 rx_s1, rx_s2, rx_s3;
    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [2:0]           bit_idx, bit_nx;
    logic [DATA_BITS-1:0] sh, sh_nx;
    logic                 done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            sh      <= sh_nx;
            // A completed byte only loads when the holding register is free
            // or being drained this cycle; otherwise it is dropped.
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= sh;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        sh_nx    = sh;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    cnt_nx   = HALF;
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rx_s2) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx   = FULL;
                        bit_nx   = '0;
                        state_nx = DATA;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    sh_nx  = {rx_s2, sh[DATA_BITS-1:1]};
                    cnt_nx = FULL;
                    if (bit_idx == LAST) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    done     = rx_s2;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART top: instantiates the receiver and implements the
// transmitter inline. Bit period is 2*BAUDSEL clocks.
module uart
    import uart_pkg::*;
#(
    parameter int unsigned BAUDSEL = 625
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data
);

    localparam int unsigned CW = cnt_width(BAUDSEL);
    localparam logic [CW-1:0] FULL = CW'(2 * BAUDSEL - 1);
    localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

    uart_rx #(
        .BAUDSEL (BAUDSEL)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data)
    );

    state_t               tx_state, tx_state_nx;
    logic [CW-1:0]        tx_cnt, tx_cnt_nx;
    logic [2:0]           tx_bit, tx_bit_nx;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_nx;
    logic                 tx_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_sh    <= tx_sh_nx;
            tx       <= tx_nx;
        end
    end

    // tx is registered, so each level is set up on the edge that ends the
    // previous bit; the shifter is advanced one bit ahead of the line.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_sh_nx    = tx_sh;
        tx_nx       = tx;
        tx_ready    = 1'b0;
        unique case (tx_state)
            IDLE: begin
                tx_ready = 1'b1;
                tx_nx    = 1'b1;
                if (tx_valid) begin
                    tx_sh_nx    = tx_data;
                    tx_cnt_nx   = FULL;
                    tx_nx       = 1'b0;
                    tx_state_nx = START;
                end
            end
            START: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nx   = FULL;
                    tx_bit_nx   = '0;
                    tx_nx       = tx_sh[0];
                    tx_state_nx = DATA;
                end else begin
                    tx_cnt_nx = tx_cnt - CW'(1);
                end
            end
            DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nx = FULL;
                    if (tx_bit == LAST) begin
                        tx_nx       = 1'b1;
                        tx_state_nx = STOP;
                    end else begin
                        tx_bit_nx = tx_bit + 3'd1;
                        tx_sh_nx  = {1'b0, tx_sh[DATA_BITS-1:1]};
                        tx_nx     = tx_sh[1];
                    end
                end else begin
                    tx_cnt_nx = tx_cnt - CW'(1);
                end
            end
            STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_nx = IDLE;
                end else begin
                    tx_cnt_nx = tx_cnt - CW'(1);
                end
            end
            default: tx_state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart.sv
// Directed self-checking bench for uart with BAUDSEL=2 (4 clocks per bit).
module tb_uart;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       tx;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  rxq[$];
    int unsigned vcnt = 0;

    uart #(
        .BAUDSEL (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .tx       (tx),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            vcnt++;
            if (rx_ready) rxq.push_back(rx_data);
        end
    end

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(4);
        end
        rx = stop_bit;
        tick(4);
        rx = 1'b1;
    endtask

    initial begin
        logic [9:0] txexp;
        logic [7:0] bytes [10];
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // 1. reset mid-transmission
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(10);
        chk("tx_low_before_reset", tx, 1'b0);
        chk("tx_busy_before_reset", tx_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("idle_tx", tx, 1'b1);
        chk("idle_tx_ready", tx_ready, 1'b1);
        chk("idle_no_rx_valid", vcnt, 0);

        // 2. single receive
        send_frame(8'h01, 1'b1);
        tick(4);
        chk("single_count", rxq.size(), 1);
        chk("single_pulses", vcnt, 1);
        if (rxq.size() > 0) chk("single_data", rxq[0], 8'h01);
        rxq.delete();
        vcnt = 0;

        // 3. back-to-back receive
        bytes = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h00};
        bytes[9] = 8'h35;
        bytes[8] = 8'h34;
        bytes[7] = 8'h33;
        bytes[6] = 8'h32;
        bytes[5] = 8'h31;
        for (int i = 0; i < 10; i++) send_frame(bytes[i], 1'b1);
        tick(6);
        chk("b2b_count", rxq.size(), 10);
        chk("b2b_pulses", vcnt, 10);
        for (int i = 0; i < 10; i++)
            if (i < rxq.size()) chk($sformatf("b2b_data%0d", i), rxq[i], bytes[i]);
        rxq.delete();
        vcnt = 0;

        // 4. transmit 0x42 while receiving 0x5A concurrently
        txexp = 10'b1_0100_0010_0;
        chk("tx_ready_pre", tx_ready, 1'b1);
        tx_data  = 8'h42;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        chk($sformatf("tx_bit%0d_%0d", i, j), tx, txexp[i]);
                        chk($sformatf("tx_busy%0d_%0d", i, j), tx_ready, 1'b0);
                        tx_valid = (i == 5 && j == 0);
                        tick();
                    end
                end
                tx_valid = 1'b0;
                chk("tx_ready_after", tx_ready, 1'b1);
                chk("tx_idle_after", tx, 1'b1);
                tick(8);
                chk("tx_ignored_req", tx, 1'b1);
                chk("tx_ready_stays", tx_ready, 1'b1);
            end
            begin
                send_frame(8'h5A, 1'b1);
            end
        join
        tick(4);
        chk("duplex_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("duplex_data", rxq[0], 8'h5A);
        rxq.delete();
        vcnt = 0;

        // 5. start glitch and framing error
        rx = 1'b0;
        tick();
        rx = 1'b1;
        tick(20);
        chk("glitch_no_valid", vcnt, 0);
        send_frame(8'h55, 1'b0);
        tick(8);
        chk("framing_no_valid", vcnt, 0);
        send_frame(8'hA5, 1'b1);
        tick(4);
        chk("after_frame_err_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("after_frame_err_data", rxq[0], 8'hA5);
        rxq.delete();
        vcnt = 0;

        // 6. backpressure
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(6);
        chk("bp_valid_held", rx_valid, 1'b1);
        chk("bp_data_held", rx_data, 8'h11);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("bp_cleared", rx_valid, 1'b0);
        tick(20);
        chk("bp_stays_clear", rx_valid, 1'b0);
        chk("bp_accept_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("bp_accept_data", rxq[0], 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
